// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter: widths, register
// count, grant source encodings and small decode helpers.
package wb_port_arbiter_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   // Grant source encoding, also handy when tracing which unit owned the port
   localparam logic [1:0] SRC_NONE = 2'd0;
   localparam logic [1:0] SRC_PIPE = 2'd1;
   localparam logic [1:0] SRC_LSU  = 2'd2;
   localparam logic [1:0] SRC_MDU  = 2'd3;

   function automatic logic rd_is_live(input logic [REG_ADDR_W-1:0] rd);
      return rd != '0;
   endfunction

   // One-hot select of a register; x0 maps to an empty mask so it is never tracked
   function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
      logic [NUM_REGS-1:0] mask;
      mask = '0;
      if (rd_is_live(rd)) begin
         mask[rd] = 1'b1;
      end
      return mask;
   endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard for long-latency destinations: one bit per register,
// set on issue, cleared on writeback, with two combinational busy lookups.
module wb_scoreboard
   import wb_port_arbiter_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  set_en,
   input  logic [REG_ADDR_W-1:0] set_rd,
   input  logic                  clr_en,
   input  logic [REG_ADDR_W-1:0] clr_rd,
   input  logic [REG_ADDR_W-1:0] look_a_rd,
   output logic                  look_a_busy,
   input  logic [REG_ADDR_W-1:0] look_b_rd,
   output logic                  look_b_busy,
   output logic [NUM_REGS-1:0]   busy_mask
);

   logic [NUM_REGS-1:0] set_mask;
   logic [NUM_REGS-1:0] clr_mask;
   logic [NUM_REGS-1:0] busy_next;

   always_comb begin
      set_mask = set_en ? rd_onehot(set_rd) : '0;
      clr_mask = clr_en ? rd_onehot(clr_rd) : '0;
      // A new issue to the same register outranks the retiring write
      busy_next = (busy_mask & ~clr_mask) | set_mask;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_mask <= '0;
      end else begin
         busy_mask <= busy_next;
      end
   end

   assign look_a_busy = rd_is_live(look_a_rd) && busy_mask[look_a_rd];
   assign look_b_busy = rd_is_live(look_b_rd) && busy_mask[look_b_rd];

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between pipeline, late load
// and mul/div results, with WAW stalls and a pipe starvation override.
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int XLEN         = wb_port_arbiter_pkg::XLEN
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pipe_valid,
   input  logic [REG_ADDR_W-1:0] pipe_rd,
   input  logic [XLEN-1:0]       pipe_data,
   output logic                  pipe_ready,
   input  logic                  lsu_valid,
   input  logic [REG_ADDR_W-1:0] lsu_rd,
   input  logic [XLEN-1:0]       lsu_data,
   output logic                  lsu_ready,
   input  logic                  mdu_valid,
   input  logic [REG_ADDR_W-1:0] mdu_rd,
   input  logic [XLEN-1:0]       mdu_data,
   output logic                  mdu_ready,
   input  logic                  issue_valid,
   input  logic [REG_ADDR_W-1:0] issue_rd,
   output logic                  issue_ready,
   output logic [NUM_REGS-1:0]   busy_mask,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_waddr,
   output logic [XLEN-1:0]       rf_wdata
);

   localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   logic                  pipe_busy;
   logic                  issue_busy;
   logic                  pipe_elig;
   logic                  force_pipe;
   logic [1:0]            src;
   logic                  grant;
   logic [REG_ADDR_W-1:0] grant_rd;
   logic [XLEN-1:0]       grant_data;
   logic [CNT_W-1:0]      starve_cnt;
   logic                  sb_set_en;
   logic                  sb_clr_en;

   wb_scoreboard u_scoreboard (
      .clk         (clk),
      .rst_n       (rst_n),
      .set_en      (sb_set_en),
      .set_rd      (issue_rd),
      .clr_en      (sb_clr_en),
      .clr_rd      (grant_rd),
      .look_a_rd   (pipe_rd),
      .look_a_busy (pipe_busy),
      .look_b_rd   (issue_rd),
      .look_b_busy (issue_busy),
      .busy_mask   (busy_mask)
   );

   // A pipe write must not overtake an older long-latency write to the same rd
   assign pipe_elig  = pipe_valid && !pipe_busy;
   assign force_pipe = pipe_elig && (starve_cnt == CNT_MAX);

   always_comb begin
      src = SRC_NONE;
      if (!rst_n) begin
         src = SRC_NONE;
      end else if (force_pipe) begin
         src = SRC_PIPE;
      end else if (lsu_valid) begin
         src = SRC_LSU;
      end else if (mdu_valid) begin
         src = SRC_MDU;
      end else if (pipe_elig) begin
         src = SRC_PIPE;
      end
   end

   always_comb begin
      grant_rd   = '0;
      grant_data = '0;
      case (src)
         SRC_PIPE: begin
            grant_rd   = pipe_rd;
            grant_data = pipe_data;
         end
         SRC_LSU: begin
            grant_rd   = lsu_rd;
            grant_data = lsu_data;
         end
         SRC_MDU: begin
            grant_rd   = mdu_rd;
            grant_data = mdu_data;
         end
         default: begin
            grant_rd   = '0;
            grant_data = '0;
         end
      endcase
   end

   assign grant       = (src != SRC_NONE);
   assign pipe_ready  = (src == SRC_PIPE);
   assign lsu_ready   = (src == SRC_LSU);
   assign mdu_ready   = (src == SRC_MDU);
   assign issue_ready = rst_n && !issue_busy;

   assign sb_set_en = issue_valid && issue_ready;
   assign sb_clr_en = (src == SRC_LSU) || (src == SRC_MDU);

   // Only an eligible pipe request that loses counts; a WAW-blocked one holds
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (!pipe_valid || pipe_ready) begin
         starve_cnt <= '0;
      end else if (pipe_elig && starve_cnt != CNT_MAX) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else if (grant) begin
         rf_we    <= rd_is_live(grant_rd);
         rf_waddr <= grant_rd;
         rf_wdata <= grant_data;
      end else begin
         rf_we    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: stimulus queues expected register writes,
// a negedge monitor pops and compares them whenever rf_we is seen.
module tb_wb_port_arbiter;

   logic        clk;
   logic        rst_n;
   logic        pipe_valid;
   logic [4:0]  pipe_rd;
   logic [31:0] pipe_data;
   logic        pipe_ready;
   logic        lsu_valid;
   logic [4:0]  lsu_rd;
   logic [31:0] lsu_data;
   logic        lsu_ready;
   logic        mdu_valid;
   logic [4:0]  mdu_rd;
   logic [31:0] mdu_data;
   logic        mdu_ready;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic        issue_ready;
   logic [31:0] busy_mask;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   int errors = 0;
   int checks = 0;
   logic [36:0] exp_q[$];

   wb_port_arbiter #(.STARVE_LIMIT(4), .XLEN(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pipe_valid  (pipe_valid),
      .pipe_rd     (pipe_rd),
      .pipe_data   (pipe_data),
      .pipe_ready  (pipe_ready),
      .lsu_valid   (lsu_valid),
      .lsu_rd      (lsu_rd),
      .lsu_data    (lsu_data),
      .lsu_ready   (lsu_ready),
      .mdu_valid   (mdu_valid),
      .mdu_rd      (mdu_rd),
      .mdu_data    (mdu_data),
      .mdu_ready   (mdu_ready),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .issue_ready (issue_ready),
      .busy_mask   (busy_mask),
      .rf_we       (rf_we),
      .rf_waddr    (rf_waddr),
      .rf_wdata    (rf_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_write(input logic [4:0] rd, input logic [31:0] data);
      exp_q.push_back({rd, data});
   endtask

   task automatic chk_readies(input string nm, input logic p, input logic l, input logic m);
      chk({nm, "_pipe_ready"}, 64'(pipe_ready), 64'(p));
      chk({nm, "_lsu_ready"},  64'(lsu_ready),  64'(l));
      chk({nm, "_mdu_ready"},  64'(mdu_ready),  64'(m));
   endtask

   always @(negedge clk) begin
      if (rst_n && rf_we) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write_addr", 64'(rf_waddr), 64'hDEAD);
         end else begin
            logic [36:0] e;
            e = exp_q.pop_front();
            chk("write_addr", 64'(rf_waddr), 64'(e[36:32]));
            chk("write_data", 64'(rf_wdata), 64'(e[31:0]));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      pipe_valid = 1'b1; pipe_rd = 5'd1; pipe_data = '0;
      lsu_valid = 1'b1;  lsu_rd = 5'd2;  lsu_data = '0;
      mdu_valid = 1'b0;  mdu_rd = '0;    mdu_data = '0;
      issue_valid = 1'b0; issue_rd = 5'd3;

      // Reset state
      #2;
      chk("rst_rf_we", 64'(rf_we), 64'd0);
      chk("rst_rf_waddr", 64'(rf_waddr), 64'd0);
      chk("rst_rf_wdata", 64'(rf_wdata), 64'd0);
      chk("rst_busy_mask", 64'(busy_mask), 64'd0);
      chk_readies("rst", 1'b0, 1'b0, 1'b0);
      chk("rst_issue_ready", 64'(issue_ready), 64'd0);
      pipe_valid = 1'b0;
      lsu_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Single pipe write
      tick();
      pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_data = 32'h1234;
      @(negedge clk);
      chk_readies("pipe1", 1'b1, 1'b0, 1'b0);
      expect_write(5'd5, 32'h1234);
      tick();
      pipe_valid = 1'b0;
      @(negedge clk);
      chk("pipe1_rf_we", 64'(rf_we), 64'd1);

      // All three sources at once: lsu, then mdu, then pipe
      tick();
      lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'hA;
      mdu_valid = 1'b1; mdu_rd = 5'd4; mdu_data = 32'hB;
      pipe_valid = 1'b1; pipe_rd = 5'd6; pipe_data = 32'hC;
      @(negedge clk);
      chk_readies("prio_c1", 1'b0, 1'b1, 1'b0);
      expect_write(5'd3, 32'hA);
      tick();
      lsu_valid = 1'b0;
      @(negedge clk);
      chk_readies("prio_c2", 1'b0, 1'b0, 1'b1);
      expect_write(5'd4, 32'hB);
      tick();
      mdu_valid = 1'b0;
      @(negedge clk);
      chk_readies("prio_c3", 1'b1, 1'b0, 1'b0);
      expect_write(5'd6, 32'hC);
      tick();
      pipe_valid = 1'b0;

      // WAW: issue rd7, pipe rd7 waits for the mdu result
      issue_valid = 1'b1; issue_rd = 5'd7;
      @(negedge clk);
      chk("waw_issue_ready", 64'(issue_ready), 64'd1);
      tick();
      issue_valid = 1'b0;
      @(negedge clk);
      chk("waw_busy_set", 64'(busy_mask), 64'h80);
      chk("waw_issue_blocked", 64'(issue_ready), 64'd0);
      tick();
      pipe_valid = 1'b1; pipe_rd = 5'd7; pipe_data = 32'h77;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("waw_pipe_blocked", 64'(pipe_ready), 64'd0);
         tick();
      end
      mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'h70;
      @(negedge clk);
      chk_readies("waw_mdu", 1'b0, 1'b0, 1'b1);
      expect_write(5'd7, 32'h70);
      tick();
      mdu_valid = 1'b0;
      @(negedge clk);
      chk("waw_busy_clr", 64'(busy_mask), 64'd0);
      chk_readies("waw_pipe_go", 1'b1, 1'b0, 1'b0);
      expect_write(5'd7, 32'h77);
      tick();
      pipe_valid = 1'b0;

      // Starvation: lsu held, pipe wins on the fifth cycle
      lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_data = 32'h100;
      pipe_valid = 1'b1; pipe_rd = 5'd9; pipe_data = 32'h99;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk_readies("starve_lsu", 1'b0, 1'b1, 1'b0);
         expect_write(lsu_rd, lsu_data);
         tick();
         lsu_rd = lsu_rd + 5'd1;
         lsu_data = lsu_data + 32'h1;
      end
      @(negedge clk);
      chk_readies("starve_force", 1'b1, 1'b0, 1'b0);
      expect_write(5'd9, 32'h99);
      tick();
      pipe_data = 32'h9A;
      @(negedge clk);
      chk_readies("starve_cleared", 1'b0, 1'b1, 1'b0);
      expect_write(lsu_rd, lsu_data);
      tick();
      lsu_valid = 1'b0;
      pipe_valid = 1'b0;

      // Pipe write to x0 and issue to x0
      pipe_valid = 1'b1; pipe_rd = 5'd0; pipe_data = 32'hFFFF;
      issue_valid = 1'b1; issue_rd = 5'd0;
      @(negedge clk);
      chk("x0_pipe_ready", 64'(pipe_ready), 64'd1);
      chk("x0_issue_ready", 64'(issue_ready), 64'd1);
      tick();
      pipe_valid = 1'b0;
      issue_valid = 1'b0;
      @(negedge clk);
      chk("x0_rf_we", 64'(rf_we), 64'd0);
      chk("x0_busy_mask", 64'(busy_mask), 64'd0);

      // Same-edge set and clear of x8: set wins
      tick();
      issue_valid = 1'b1; issue_rd = 5'd8;
      lsu_valid = 1'b1; lsu_rd = 5'd8; lsu_data = 32'h88;
      @(negedge clk);
      chk("setclr_issue_ready", 64'(issue_ready), 64'd1);
      chk("setclr_lsu_ready", 64'(lsu_ready), 64'd1);
      expect_write(5'd8, 32'h88);
      tick();
      issue_valid = 1'b0;
      lsu_valid = 1'b0;
      @(negedge clk);
      chk("setclr_busy", 64'(busy_mask), 64'h100);

      // Asynchronous reset mid-stream
      tick();
      mdu_valid = 1'b1; mdu_rd = 5'd12; mdu_data = 32'hC0DE;
      @(negedge clk);
      chk("arst_mdu_ready", 64'(mdu_ready), 64'd1);
      tick();
      mdu_valid = 1'b0;
      pipe_valid = 1'b1; pipe_rd = 5'd2; pipe_data = 32'h22;
      chk("arst_pre_rf_we", 64'(rf_we), 64'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_rf_we", 64'(rf_we), 64'd0);
      chk("arst_rf_waddr", 64'(rf_waddr), 64'd0);
      chk("arst_busy_mask", 64'(busy_mask), 64'd0);
      chk("arst_pipe_ready", 64'(pipe_ready), 64'd0);
      chk("arst_issue_ready", 64'(issue_ready), 64'd0);
      pipe_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      @(negedge clk);
      chk("writes_outstanding", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Shares the register file's single write port between three result sources:
- the in-order pipeline writeback (ALU, CSR, jump link, aligned load),
- the load/store unit's late load responses,
- the multiply/divide unit.

It also keeps a per-register pending scoreboard for long-latency destinations, so it can stall WAW hazards and report busy registers to the issue stage. It sits between the writeback selection logic and the register file.

Parameters:
STARVE_LIMIT, 4, consecutive cycles a blocked pipe request may lose arbitration before it is forced to win
XLEN, 32, data width of results and rf_wdata

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous assert, active-low
pipe_valid  input  1  pipeline writeback request (already qualified by the writeback enable)
pipe_rd  input  5  pipeline destination register
pipe_data  input  XLEN  pipeline result
pipe_ready  output  1  pipeline request accepted this cycle
lsu_valid  input  1  late load response valid
lsu_rd  input  5  load destination
lsu_data  input  XLEN  load data
lsu_ready  output  1  load response accepted
mdu_valid  input  1  mul/div result valid
mdu_rd  input  5  mul/div destination
mdu_data  input  XLEN  mul/div result
mdu_ready  output  1  mul/div result accepted
issue_valid  input  1  a long-latency op (late load or mul/div) is issuing
issue_rd  input  5  its destination
issue_ready  output  1  issue allowed (no WAW on issue_rd)
busy_mask  output  32  scoreboard; bit i set means x[i] has an outstanding long-latency write
rf_we  output  1  register file write enable (registered)
rf_waddr  output  5  register file write address (registered)
rf_wdata  output  XLEN  register file write data (registered)

Behaviour:
- Reset (rst_n low, asynchronous):
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - busy_mask=0; starvation counter=0.
  - All ready outputs are combinationally 0 while rst_n is low.
  - A request in flight at reset is dropped; its scoreboard bit is cleared.
- Handshake: a transfer occurs on a rising edge where valid and ready are both 1. The arbiter never stalls the register file; at most one grant per cycle.
- Priority: lsu > mdu > pipe, with two exceptions:
  - Pipe WAW block: the pipe is not eligible when pipe_rd != 0 and busy_mask[pipe_rd]=1. In that case pipe_ready=0 regardless of priority.
  - Starvation override: when the starvation counter equals STARVE_LIMIT and the pipe is eligible, the pipe wins that cycle.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) each cycle an eligible pipe request loses.
  - Clears when the pipe is granted or pipe_valid=0.
  - Does not increment while the pipe is WAW-blocked.
- Output stage (latency 1 cycle): the granted request's rd/data are registered into rf_waddr/rf_wdata.
  - rf_we = 1 only if a grant occurred and the granted rd != 0.
  - A grant to x0 is accepted (ready=1) but produces rf_we=0.
  - When there is no grant, rf_we=0 and rf_waddr/rf_wdata hold their previous values.
- Scoreboard:
  - Set: a transfer on issue with issue_rd != 0 sets busy_mask[issue_rd] at the edge.
  - Clear: busy_mask[rd] clears at the edge where an lsu or mdu grant for that rd is accepted, so the bit is clear in the same cycle rf_we shows the write.
  - Same-edge set and clear of the same register: set wins.
  - issue_ready = !(issue_rd != 0 && busy_mask[issue_rd]) && rst_n. x0 never blocks.
  - An lsu/mdu grant to a register whose bit is already clear is legal; no error is flagged.
- Ready outputs are combinational from valid/rd/busy_mask/counter. Valids must not depend on readies.

Decomposition:
- Shared package: XLEN, REG_ADDR_W=5, the number of registers (32), and the source encoding constants SRC_NONE/PIPE/LSU/MDU (2 bits), which are also used for debug tracing.
- One sub-module, wb_scoreboard: holds busy_mask, with set/clear ports and busy lookup. The arbiter and the output register stay in the top block.

Test Plan:
- Reset, then pipe_valid, pipe_rd=5, pipe_data=0x1234 -> pipe_ready=1; next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234.
- lsu (rd=3, 0xA), mdu (rd=4, 0xB) and pipe (rd=6, 0xC) all valid together -> writes on consecutive cycles in order rd3, rd4, rd6, one per cycle. Each ready pulses only in its own grant cycle.
- Issue rd=7 -> busy_mask[7]=1. Pipe request rd=7 -> pipe_ready=0 until the mdu returns rd=7. busy_mask[7] clears at the mdu grant edge, and the pipe is granted the following cycle (WAW order preserved).
- lsu_valid held continuously with varying rd and pipe valid (rd=9), STARVE_LIMIT=4 -> lsu wins 4 cycles, the pipe wins the 5th, and the counter returns to 0.
- Pipe request with rd=0, data 0xFFFF -> pipe_ready=1, next cycle rf_we=0. issue_rd=0 -> issue_ready=1 and busy_mask unchanged.
- Issue rd=8 and an lsu grant with rd=8 on the same edge -> busy_mask[8] stays 1. Assert rst_n low mid-stream -> rf_we=0 and busy_mask=0 immediately, without waiting for a clock edge.
